// File: rtl/fir_pkg.sv
// Shared definitions for the polyphase interpolation FIR: default widths,
// oversampling encodings, FSM state encoding and the per-ratio last phase index.
package fir_pkg;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_DATA_W    = 28;
  localparam int DEF_IN_W      = 32;
  localparam int DEF_COEF_W    = 32;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_PHASE_LEN = 128;
  localparam int DEF_ACC_W     = 64;
  localparam int DEF_OUT_SHIFT = 27;

  typedef enum logic [1:0] {
    OS_1X = 2'd0,
    OS_2X = 2'd1,
    OS_4X = 2'd2,
    OS_8X = 2'd3
  } os_sel_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Highest polyphase branch index for a ratio: one output per branch per input.
  function automatic logic [2:0] last_k(input os_sel_e os);
    logic [2:0] lk;
    lk = 3'd0;
    case (os)
      OS_8X:   lk = 3'd7;
      OS_4X:   lk = 3'd3;
      OS_2X:   lk = 3'd1;
      default: lk = 3'd0;
    endcase
    return lk;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// One channel's multiply-accumulate: registered signed product followed by a
// wide accumulator. acc_sum already includes the product registered this cycle.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  acc_sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic [PROD_W-1:0] sample_ext;
  logic [PROD_W-1:0] coef_ext;
  logic [PROD_W-1:0] prod_d, prod_q;
  logic              prod_v_d, prod_v_q;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_d, acc_q;

  // Sign-extend both operands to the full product width so the low PROD_W
  // bits of an unsigned multiply are the exact two's-complement product.
  assign sample_ext = {{COEF_W{sample[DATA_W-1]}}, sample};
  assign coef_ext   = {{DATA_W{coef[COEF_W-1]}}, coef};
  assign prod_ext   = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_comb begin
    prod_d   = prod_q;
    prod_v_d = en;
    if (en) prod_d = sample_ext * coef_ext;
    acc_sum = prod_v_q ? (acc_q + prod_ext) : acc_q;
    acc_d   = clr ? '0 : acc_sum;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/fir_poly_interp.sv
// Multi-channel polyphase interpolation FIR with per-channel history RAM and a shared coefficient fetch.
// Build option FIR_ROUND_SAT_EN: round before the output shift and saturate to signed OUT_W.
module fir_poly_interp
  import fir_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IN_W      = DEF_IN_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int PHASE_LEN = DEF_PHASE_LEN,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                          pclk,
  input  logic                          reset_n,
  input  logic [1:0]                    os_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*IN_W-1:0]        in_data,
  output logic [$clog2(PHASE_LEN)+2:0]  coef_addr,
  input  logic [COEF_W-1:0]             coef_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*OUT_W-1:0]       out_data,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int LW = $clog2(PHASE_LEN);
  localparam int AW = LW + 3;

  // Handshakes: a transfer occurs on a rising pclk edge with valid and ready
  // both high; a raised valid holds its data stable until that edge, and
  // ready is never derived combinationally from valid.
  state_e                    state_q, state_d;
  os_sel_e                   os_q, os_d;
  logic [LW-1:0]             wptr_q, wptr_d;
  logic [LW-1:0]             j_q, j_d;
  logic [2:0]                k_q, k_d;
  logic                      drain_q, drain_d;
  logic                      rd_v_q, rd_v_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic [NUM_CH*OUT_W-1:0]   out_data_q, out_data_d;
  logic                      accept;
  logic                      out_fire;
  logic                      acc_clr;
  logic                      load_out;
  logic [LW-1:0]             rd_idx;
  logic [ACC_W-1:0]          acc_sum [NUM_CH];
  logic [DATA_W-1:0]         rd_sample [NUM_CH];

  assign accept   = in_ready_q & in_valid;
  assign out_fire = out_valid_q & out_ready;
  // wptr already points past the newest sample, so tap j reads newest-first.
  assign rd_idx   = wptr_q - LW'(1) - j_q;

  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] acc);
`ifdef FIR_ROUND_SAT_EN
    logic [ACC_W-1:0] rnd;
    logic [ACC_W-1:0] shf;
    logic [OUT_W-1:0] res;
    rnd = acc + (ACC_W'(1) << (OUT_SHIFT - 1));
    shf = ACC_W'($signed(rnd) >>> OUT_SHIFT);
    if ((&shf[ACC_W-1:OUT_W-1]) || !(|shf[ACC_W-1:OUT_W-1])) begin
      res = shf[OUT_W-1:0];
    end else if (shf[ACC_W-1]) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return res;
`else
    return OUT_W'($signed(acc) >>> OUT_SHIFT);
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    wptr_d      = wptr_q;
    j_d         = j_q;
    k_d         = k_q;
    drain_d     = drain_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    acc_clr     = 1'b0;
    load_out    = 1'b0;
    rd_v_d      = (state_q == ST_MAC);
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wptr_d  = wptr_q + LW'(1);
          os_d    = os_sel_e'(os_sel);
          k_d     = 3'd0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (j_q == LW'(PHASE_LEN - 1)) begin
          j_d     = '0;
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + LW'(1);
        end
      end
      ST_DRAIN: begin
        // Two cycles let the last tap pass the read and product registers.
        if (drain_q) begin
          load_out    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          acc_clr     = 1'b1;
          j_d         = '0;
          if (k_q == last_k(os_q)) begin
            state_d = ST_LOAD;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    in_ready_d = (state_d == ST_LOAD);
  end

  always_comb begin
    coef_addr = '0;
    case (os_q)
      OS_8X:   coef_addr = {j_q, k_q};
      OS_4X:   coef_addr = AW'({j_q, k_q[1:0]});
      OS_2X:   coef_addr = AW'({j_q, k_q[0]});
      default: coef_addr = AW'(j_q);
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    if (load_out) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_data_d[c*OUT_W +: OUT_W] = scale(acc_sum[c]);
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      os_q        <= OS_1X;
      wptr_q      <= '0;
      j_q         <= '0;
      k_q         <= 3'd0;
      drain_q     <= 1'b0;
      rd_v_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      os_q        <= os_d;
      wptr_q      <= wptr_d;
      j_q         <= j_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      rd_v_q      <= rd_v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] hist_q [PHASE_LEN];
    logic [DATA_W-1:0] rd_q;
    logic              unused_lsbs;

    // Only the DATA_W MSBs of each input word are stored.
    assign unused_lsbs   = ^in_data[ch*IN_W +: (IN_W - DATA_W)];
    assign rd_sample[ch] = rd_q;

    always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < PHASE_LEN; i++) hist_q[i] <= '0;
        rd_q <= '0;
      end else begin
        if (accept) hist_q[wptr_q] <= in_data[ch*IN_W + IN_W - 1 -: DATA_W];
        rd_q <= hist_q[rd_idx];
      end
    end

    fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_mac (
      .pclk    (pclk),
      .reset_n (reset_n),
      .clr     (acc_clr),
      .en      (rd_v_q),
      .sample  (rd_sample[ch]),
      .coef    (coef_data),
      .acc_sum (acc_sum[ch])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
